// File: rtl/ddr2_ck_mon_pkg.sv
// Shared types and constants for the DDR2 forwarded-clock loopback monitor.
//   mon_state_t : 2-bit FSM state (IDLE/ACQUIRE/LOCKED/LOST)
//   ERR_W_DEF   : default error counter width
package ddr2_ck_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } mon_state_t;

    localparam int ERR_W_DEF = 16;

endpackage

// File: rtl/ddr2_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count up by one (held at all-ones once reached)
//   clr        : clear to zero; wins over a simultaneous inc
//   cnt        : registered count
module ddr2_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ddr2_ck_loopback_monitor.sv
// Checks the looped-back DDR2 clock samples (one rise/fall pair per clk),
// acquires lock to the pair phase and tracks loss of lock and errors.
//   clk, rst_n       : controller clock, async active-low reset
//   enable           : arm the monitor; low forces IDLE
//   clr              : clears err_cnt and lost_sticky (wins over set/inc)
//   ck_rise, ck_fall : rising/falling-edge loopback samples
//   locked           : phase acquired and stable
//   phase            : captured reference (0 = rise0/fall1, 1 = rise1/fall0)
//   err_cnt          : saturating mismatch count while locked
//   lost_sticky      : set on every LOCKED->LOST transition
//   state            : current FSM state
module ddr2_ck_loopback_monitor
    import ddr2_ck_mon_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr,
    input  logic             ck_rise,
    input  logic             ck_fall,
    output logic             locked,
    output logic             phase,
    output logic [ERR_W-1:0] err_cnt,
    output logic             lost_sticky,
    output logic [1:0]       state
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    mon_state_t        st_q, st_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              ref_q, ref_d;
    logic              locked_q;
    logic              lost_q;
    logic              err_inc;
    logic              lost_set;

    // A pair is valid when the two samples differ; its phase is the rise sample.
    logic pair_vld, pair_match;
    assign pair_vld   = ck_rise ^ ck_fall;
    assign pair_match = pair_vld && (ck_rise == ref_q);

    always_comb begin
        st_d     = st_q;
        run_d    = run_q;
        miss_d   = miss_q;
        ref_d    = ref_q;
        err_inc  = 1'b0;
        lost_set = 1'b0;
        case (st_q)
            ST_IDLE: begin
                run_d  = '0;
                miss_d = '0;
                if (enable) st_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                miss_d = '0;
                if (!pair_vld) begin
                    run_d = '0;
                end else if ((run_q == '0) || !pair_match) begin
                    // Fresh start or phase disagreement: restart on this pair.
                    ref_d = ck_rise;
                    run_d = RUN_W'(1);
                end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                    st_d  = ST_LOCKED;
                    run_d = '0;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end
            ST_LOCKED: begin
                if (pair_match) begin
                    miss_d = '0;
                end else begin
                    err_inc = 1'b1;
                    if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                        st_d     = ST_LOST;
                        lost_set = 1'b1;
                        miss_d   = '0;
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end
            end
            ST_LOST: begin
                run_d  = '0;
                miss_d = '0;
                st_d   = ST_ACQUIRE;
            end
            default: st_d = ST_IDLE;
        endcase
        // Disarming overrides everything; error bookkeeping stops with it.
        if (!enable) begin
            st_d     = ST_IDLE;
            err_inc  = 1'b0;
            lost_set = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= ST_IDLE;
            run_q    <= '0;
            miss_q   <= '0;
            ref_q    <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            run_q    <= run_d;
            miss_q   <= miss_d;
            ref_q    <= ref_d;
            locked_q <= (st_d == ST_LOCKED);
            if (clr)           lost_q <= 1'b0;
            else if (lost_set) lost_q <= 1'b1;
        end
    end

    ddr2_sat_cnt #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (clr),
        .cnt   (err_cnt)
    );

    assign locked      = locked_q;
    assign phase       = ref_q;
    assign lost_sticky = lost_q;
    assign state       = st_q;

endmodule

// File: tb/tb_ddr2_ck_loopback_monitor.sv
module tb_ddr2_ck_loopback_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       clr;
    logic       ck_rise;
    logic       ck_fall;
    logic       locked;
    logic       phase;
    logic [3:0] err_cnt;
    logic       lost_sticky;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    ddr2_ck_loopback_monitor #(.LOCK_CNT(16), .LOSS_CNT(4), .ERR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clr         (clr),
        .ck_rise     (ck_rise),
        .ck_fall     (ck_fall),
        .locked      (locked),
        .phase       (phase),
        .err_cnt     (err_cnt),
        .lost_sticky (lost_sticky),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one pair for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic f);
        ck_rise = r;
        ck_fall = f;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input logic r, input logic f);
        for (int i = 0; i < n; i++) step(r, f);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; clr = 1'b0; ck_rise = 1'b0; ck_fall = 1'b0;
        #12;
        chk("rst_state",  state, 0);
        chk("rst_locked", locked, 0);
        chk("rst_phase",  phase, 0);
        chk("rst_err",    err_cnt, 0);
        chk("rst_lost",   lost_sticky, 0);
        rst_n = 1'b1;

        // Clean lock: enable cycle, then 16 matching (0,1) pairs.
        enable = 1'b1;
        step(0, 1);
        chk("acq_enter", state, 1);
        steps(15, 0, 1);
        chk("lock_not_yet", locked, 0);
        step(0, 1);
        chk("lock_locked", locked, 1);
        chk("lock_state",  state, 2);
        chk("lock_phase",  phase, 0);
        chk("lock_err",    err_cnt, 0);

        // Loss: 3 invalid, 1 good (clears miss), then 4 invalid.
        steps(3, 1, 1);
        chk("loss_err3",    err_cnt, 3);
        chk("loss_hold",    locked, 1);
        step(0, 1);
        chk("loss_err3b",   err_cnt, 3);
        steps(3, 0, 0);
        chk("loss_still",   locked, 1);
        chk("loss_err6",    err_cnt, 6);
        step(0, 0);
        chk("loss_unlock",  locked, 0);
        chk("loss_state",   state, 3);
        chk("loss_sticky",  lost_sticky, 1);
        chk("loss_err7",    err_cnt, 7);
        step(1, 0);
        chk("lost_to_acq",  state, 1);

        // Relock with the opposite phase.
        steps(15, 1, 0);
        chk("relock_not_yet", locked, 0);
        step(1, 0);
        chk("relock_locked",  locked, 1);
        chk("relock_phase",   phase, 1);

        // Phase flip while locked counts as mismatches: 4 -> loss, err 11.
        steps(4, 0, 1);
        chk("flip_unlock", locked, 0);
        chk("flip_err11",  err_cnt, 11);
        step(0, 1);
        chk("flip_acq",    state, 1);

        // Glitch during acquire restarts the run.
        steps(10, 0, 1);
        step(1, 1);
        steps(15, 0, 1);
        chk("glitch_not_yet", locked, 0);
        step(0, 1);
        chk("glitch_locked",  locked, 1);
        chk("glitch_phase",   phase, 0);
        chk("glitch_err",     err_cnt, 11);

        // 4 more mismatches: err 15, loss.
        steps(4, 1, 1);
        chk("sat_err15",  err_cnt, 15);
        chk("sat_state",  state, 3);
        step(0, 1);

        // Phase change during acquire: (1,0)x5 then (0,1)x16.
        steps(5, 1, 0);
        chk("pch_phase1",   phase, 1);
        steps(15, 0, 1);
        chk("pch_not_yet",  locked, 0);
        step(0, 1);
        chk("pch_locked",   locked, 1);
        chk("pch_phase0",   phase, 0);

        // Saturation holds at 15.
        steps(3, 0, 0);
        chk("sat_hold",     err_cnt, 15);
        chk("sat_locked",   locked, 1);

        // clr coincides with the 4th mismatch: err and sticky both end at 0.
        clr = 1'b1;
        step(0, 0);
        clr = 1'b0;
        chk("clr_err",      err_cnt, 0);
        chk("clr_sticky",   lost_sticky, 0);
        chk("clr_state",    state, 3);
        chk("clr_unlock",   locked, 0);
        step(0, 1);
        steps(16, 0, 1);
        chk("dis_locked",   locked, 1);
        step(1, 1);
        chk("dis_err1",     err_cnt, 1);

        // Disable while locked.
        enable = 1'b0;
        step(0, 1);
        chk("dis_unlock",   locked, 0);
        chk("dis_state",    state, 0);
        chk("dis_err_keep", err_cnt, 1);

        // Async reset mid-acquire.
        enable = 1'b1;
        step(1, 0);
        steps(5, 1, 0);
        chk("ra_state", state, 1);
        chk("ra_phase", phase, 1);
        rst_n = 1'b0;
        #1;
        chk("ra_rst_state",  state, 0);
        chk("ra_rst_locked", locked, 0);
        chk("ra_rst_phase",  phase, 0);
        chk("ra_rst_err",    err_cnt, 0);
        chk("ra_rst_lost",   lost_sticky, 0);
        #2;
        rst_n = 1'b1;
        step(1, 0);
        chk("ra_resume", state, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
